// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the multiply/divide issue stage: md op codes, FSM states,
// calculator op codes and the request/write bundles passed between blocks.
package md_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam logic [1:0] CAL_MULT  = 2'd0;
  localparam logic [1:0] CAL_MULTU = 2'd1;
  localparam logic [1:0] CAL_DIV   = 2'd2;
  localparam logic [1:0] CAL_DIVU  = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } calc_req_t;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } hilo_wr_t;

  // Reserved code 7 falls through to "not a calculator op".
  function automatic logic is_calc_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic [1:0] cal_op_of(input logic [2:0] op);
    logic [1:0] r;
    r = CAL_MULTU;
    case (op)
      MD_MULT: r = CAL_MULT;
      MD_DIV:  r = CAL_DIV;
      MD_DIVU: r = CAL_DIVU;
      default: r = CAL_MULTU;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_issue_ctrl_hilo_regs.sv
// Architectural HI/LO register pair. With HILO_FWD_EN defined, a same-cycle write
// is forwarded to the outputs; otherwise the outputs are purely registered.
module md_issue_ctrl_hilo_regs
  import md_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  hilo_wr_t    hi_wr,
  input  hilo_wr_t    lo_wr,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [31:0] hi_q, lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_wr.we) hi_q <= hi_wr.data;
      if (lo_wr.we) lo_q <= lo_wr.data;
    end
  end

`ifdef HILO_FWD_EN
  // Bypass closes the MFHI/MFLO-after-write hazard without a decode bubble.
  assign hi_out = hi_wr.we ? hi_wr.data : hi_q;
  assign lo_out = lo_wr.we ? lo_wr.data : lo_q;
`else
  assign hi_out = hi_q;
  assign lo_out = lo_q;
`endif

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue/writeback control for the multiply/divide calculator.
// Optional HI/LO write forwarding is enabled by defining HILO_FWD_EN.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 48,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        md_err,
  output logic        calc_ena,
  output logic [1:0]  calc_op,
  output logic [31:0] calc_a,
  output logic [31:0] calc_b,
  input  logic [31:0] calc_lo,
  input  logic [31:0] calc_hi,
  input  logic        calc_finish
);

  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(MIN_WAIT - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             err_q;
  calc_req_t        req_q;

  logic     idle, issue, mthi_go, mtlo_go, cap;
  hilo_wr_t hi_wr, lo_wr;

  assign idle    = (state_q == ST_IDLE);
  assign issue   = idle && op_valid && !flush && is_calc_op(op);
  assign mthi_go = idle && op_valid && !flush && (op == MD_MTHI);
  assign mtlo_go = idle && op_valid && !flush && (op == MD_MTLO);
  // Finish is only trusted after the ARM window has masked the pre-busy glitch.
  assign cap     = (state_q == ST_WAIT) && calc_finish && !flush;

  // busy_q covers ARM/WAIT; the issue cycle stalls combinationally.
  assign stall    = busy_q | issue;
  assign calc_ena = busy_q;
  assign calc_op  = req_q.op;
  assign calc_a   = req_q.a;
  assign calc_b   = req_q.b;
  assign md_err   = err_q;

  always_comb begin
    hi_wr      = '0;
    lo_wr      = '0;
    hi_wr.we   = mthi_go | cap;
    hi_wr.data = cap ? calc_hi : rs_val;
    lo_wr.we   = mtlo_go | cap;
    lo_wr.data = cap ? calc_lo : rs_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= '{op: CAL_MULTU, a: 32'd0, b: 32'd0};
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            req_q   <= '{op: cal_op_of(op), a: rs_val, b: rt_val};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (cnt_q == ARM_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (calc_finish) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else if (cnt_q == WAIT_LAST) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // One idle-enable cycle guarantees a fresh calc_ena rising edge per op.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  md_issue_ctrl_hilo_regs u_hilo (
    .clk    (clk),
    .reset  (reset),
    .hi_wr  (hi_wr),
    .lo_wr  (lo_wr),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: calculator model, per-cycle reference model, directed and random ops.
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  localparam int MIN_WAIT = 2;
  localparam int TIMEOUT  = 48;

  logic        clk, reset, op_valid, flush, calc_finish;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, calc_lo, calc_hi;
  logic        stall, md_err, calc_ena;
  logic [1:0]  calc_op;
  logic [31:0] hi_out, lo_out, calc_a, calc_b;

  int checks = 0;
  int errors = 0;

  bit rand_calc = 0;
  int dir_lat   = 7;
  bit dir_glitch = 0;

  md_issue_ctrl #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .stall(stall), .hi_out(hi_out), .lo_out(lo_out),
    .md_err(md_err), .calc_ena(calc_ena), .calc_op(calc_op), .calc_a(calc_a),
    .calc_b(calc_b), .calc_lo(calc_lo), .calc_hi(calc_hi), .calc_finish(calc_finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi, lo} as the calculator defines them.
  function automatic logic [63:0] calc_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    res = '0;
    case (o)
      CAL_MULT:  begin q = sa * sb; res = q; end
      CAL_MULTU: begin p = ua * ub; res = p; end
      CAL_DIV: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Calculator: finish is a level raised once enable has been high for lat cycles
  // (lat=0 never finishes); an optional glitch pulses finish with junk data early.
  initial begin
    int ena_cyc, lat;
    bit glitch;
    logic [63:0] res;
    calc_finish = 0; calc_hi = 0; calc_lo = 0;
    ena_cyc = 0; lat = 0; glitch = 0;
    forever begin
      @(posedge clk); #1;
      if (!calc_ena) begin
        ena_cyc = 0;
        calc_finish = 0;
      end else begin
        ena_cyc++;
        if (ena_cyc == 1) begin
          if (rand_calc) begin
            lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12));
            glitch = ($urandom_range(0, 2) == 0);
          end else begin
            lat = dir_lat;
            glitch = dir_glitch;
          end
        end
        if (glitch && ena_cyc <= MIN_WAIT) begin
          calc_finish = 1; calc_hi = 32'hDEADBEEF; calc_lo = 32'hBADC0FFE;
        end else if (lat != 0 && ena_cyc >= lat) begin
          res = calc_result(calc_op, calc_a, calc_b);
          calc_finish = 1; calc_hi = res[63:32]; calc_lo = res[31:0];
        end else begin
          calc_finish = 0; calc_hi = $urandom; calc_lo = $urandom;
        end
      end
    end
  end

  // Reference model: m_age counts enable-high cycles of the op in flight
  // (1..MIN_WAIT masked, beyond that finish is honoured); m_done marks the retire cycle.
  initial begin
    int m_age;
    bit m_done, m_err, idle, e_stall;
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [1:0]  m_op;
    m_age = 0; m_done = 0; m_err = 0; m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = CAL_MULTU;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_age = 0; m_done = 0; m_err = 0; m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = CAL_MULTU;
      end
      idle    = (m_age == 0) && !m_done;
      e_stall = (m_age > 0) || (idle && op_valid && !flush && op >= 3'd1 && op <= 3'd4);
      chk("stall",    32'(stall),    32'(e_stall));
      chk("calc_ena", 32'(calc_ena), 32'(m_age > 0));
      chk("calc_op",  32'(calc_op),  32'(m_op));
      chk("calc_a",   calc_a,        m_a);
      chk("calc_b",   calc_b,        m_b);
      chk("hi_out",   hi_out,        m_hi);
      chk("lo_out",   lo_out,        m_lo);
      chk("md_err",   32'(md_err),   32'(m_err));
      if (reset) begin
        if (flush) begin
          m_age = 0; m_done = 0;
        end else if (m_done) begin
          m_done = 0;
        end else if (m_age > 0) begin
          if (m_age > MIN_WAIT && calc_finish) begin
            m_hi = calc_hi; m_lo = calc_lo; m_age = 0; m_done = 1;
          end else if (m_age == MIN_WAIT + TIMEOUT) begin
            m_err = 1; m_age = 0; m_done = 1;
          end else begin
            m_age++;
          end
        end else if (op_valid) begin
          if (op >= 3'd1 && op <= 3'd4) begin
            m_a = rs_val; m_b = rt_val; m_age = 1;
            m_op = (op == 3'd1) ? CAL_MULT : (op == 3'd2) ? CAL_MULTU :
                   (op == 3'd3) ? CAL_DIV  : CAL_DIVU;
          end else if (op == 3'd5) m_hi = rs_val;
          else if (op == 3'd6) m_lo = rs_val;
        end
      end
    end
  end

  // Pipeline view: hold the instruction while stalled and through its retire
  // cycle; n returns the number of cycles spent including the retire cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    n = 0;
    op_valid = 1; op = o; rs_val = a; rt_val = b;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 200);
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL op_timeout: stall still high after %0d cycles, expected release", n);
    end
    @(posedge clk); #1;
    op_valid = 0; op = MD_NONE;
  endtask

  initial begin
    int n;
    reset = 0; op_valid = 0; op = MD_NONE; rs_val = 0; rt_val = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ena", 32'(calc_ena), 32'h0);
    chk("rst_op", 32'(calc_op), 32'(CAL_MULTU));
    reset = 1;
    @(posedge clk); #1;

    dir_lat = 7; dir_glitch = 0;
    do_op(MD_MULT, 32'hFFFFFFFF, 32'h00000002, n);
    chk("mult_stall_cycles", 32'(n - 1), 32'd8);
    chk("mult_hi", hi_out, 32'hFFFFFFFF);
    chk("mult_lo", lo_out, 32'hFFFFFFFE);

    do_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, n);
    chk("multu_hi", hi_out, 32'h00000001);
    chk("multu_lo", lo_out, 32'hFFFFFFFE);

    dir_lat = 4;
    do_op(MD_DIV, 32'hFFFFFFF9, 32'h00000002, n);
    chk("div_hi", hi_out, 32'hFFFFFFFF);
    chk("div_lo", lo_out, 32'hFFFFFFFD);
    do_op(MD_DIVU, 32'd100, 32'd7, n);
    chk("divu_hi", hi_out, 32'h00000002);
    chk("divu_lo", lo_out, 32'h0000000E);

    dir_lat = 5; dir_glitch = 1;
    do_op(MD_MULTU, 32'd3, 32'd5, n);
    chk("glitch_hi", hi_out, 32'h0);
    chk("glitch_lo", lo_out, 32'hF);
    dir_glitch = 0;

    // Flush in the third WAIT cycle.
    dir_lat = 20;
    op_valid = 1; op = MD_MULT; rs_val = 32'h11111111; rt_val = 32'h3;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0; op_valid = 0; op = MD_NONE;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'h0);
    chk("flush_ena", 32'(calc_ena), 32'h0);
    chk("flush_err", 32'(md_err), 32'h0);
    chk("flush_hi", hi_out, 32'h0);
    chk("flush_lo", lo_out, 32'hF);
    @(posedge clk); #1;
    do_op(MD_MTLO, 32'h12345678, 32'h0, n);
    chk("mtlo_lo", lo_out, 32'h12345678);

    dir_lat = 0;
    do_op(MD_MULT, 32'h7, 32'h9, n);
    chk("timeout_stall_cycles", 32'(n - 1), 32'(1 + MIN_WAIT + TIMEOUT));
    chk("timeout_err", 32'(md_err), 32'h1);
    chk("timeout_hi", hi_out, 32'h0);
    chk("timeout_lo", lo_out, 32'h12345678);

    // Reset while in WAIT.
    op_valid = 1; op = MD_DIV; rs_val = 32'h55; rt_val = 32'h5;
    repeat (6) begin @(posedge clk); #1; end
    op_valid = 0; op = MD_NONE; reset = 0;
    @(negedge clk);
    chk("rst2_stall", 32'(stall), 32'h0);
    chk("rst2_ena", 32'(calc_ena), 32'h0);
    chk("rst2_err", 32'(md_err), 32'h0);
    chk("rst2_lo", lo_out, 32'h0);
    chk("rst2_a", calc_a, 32'h0);
    chk("rst2_op", 32'(calc_op), 32'(CAL_MULTU));
    @(posedge clk); #1;
    reset = 1;

    rand_calc = 1;
    repeat (3000) begin
      @(posedge clk); #1;
      op_valid = ($urandom_range(0, 3) != 0);
      op       = 3'($urandom_range(0, 7));
      rs_val   = $urandom;
      rt_val   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      flush    = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    op_valid = 0; flush = 0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
